// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and constants for the stopwatch timekeeping core
package stopwatch_pkg;

    // Operating modes of the timekeeping core
    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        ADJUST = 2'd2
    } sw_state_t;

    // Digit width and per-digit maxima
    localparam int        BCD_W            = 4;
    localparam logic [3:0] ONES_MAX        = 4'd9;
    localparam int        TENS_MAX_DEFAULT = 5;

    // Bit positions inside the BLANK vector
    localparam int BLANK_MIN_TENS = 3;
    localparam int BLANK_MIN_ONES = 2;
    localparam int BLANK_SEC_TENS = 1;
    localparam int BLANK_SEC_ONES = 0;

endpackage

// File: rtl/stopwatch_bcd_mod60.sv
// rtl/stopwatch_bcd_mod60.sv - two-digit BCD counter wrapping from {tens_max,9} to 00
//
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset, digits to 0
//   inc       in   increment enable (one count per high cycle)
//   clr       in   synchronous clear to 00, wins over inc
//   tens_max  in   highest tens digit value before wrap
//   tens      out  registered tens digit
//   ones      out  registered ones digit
//   carry_out out  combinational, high when inc is applied at the maximum value
module bcd_mod60
    import stopwatch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    input  logic [BCD_W-1:0] tens_max,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             carry_out
);

    logic ones_at_max;
    logic tens_at_max;

    assign ones_at_max = (ones == ONES_MAX);
    assign tens_at_max = (tens == tens_max);
    assign carry_out   = inc && ones_at_max && tens_at_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens <= '0;
            ones <= '0;
        end else if (clr) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (ones_at_max) begin
                ones <= '0;
                tens <= tens_at_max ? '0 : tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - BCD MM:SS stopwatch with run/pause, clear and field adjust
//
// Ports:
//   CLK_REF   in   system clock
//   CLK_RES   in   asynchronous active-low reset
//   TICK_1HZ  in   count enable strobe
//   TICK_2HZ  in   adjust increment strobe
//   BLINK_PH  in   blink phase, 1 = blanked phase
//   PAUSE     in   one-cycle pulse, toggles run/pause
//   CLR       in   one-cycle pulse, clears time to 00:00
//   ADJ       in   level, selects adjust mode
//   SEL       in   level, adjust field (0 minutes, 1 seconds)
//   MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES  out  BCD digits
//   BLANK     out  per-digit blank flags [3]=MIN_TENS .. [0]=SEC_ONES
//   RUNNING   out  high in RUN
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MIN_MAX = TENS_MAX_DEFAULT,
    parameter int SEC_MAX = TENS_MAX_DEFAULT
) (
    input  logic             CLK_REF,
    input  logic             CLK_RES,
    input  logic             TICK_1HZ,
    input  logic             TICK_2HZ,
    input  logic             BLINK_PH,
    input  logic             PAUSE,
    input  logic             CLR,
    input  logic             ADJ,
    input  logic             SEL,
    output logic [BCD_W-1:0] MIN_TENS,
    output logic [BCD_W-1:0] MIN_ONES,
    output logic [BCD_W-1:0] SEC_TENS,
    output logic [BCD_W-1:0] SEC_ONES,
    output logic [3:0]       BLANK,
    output logic             RUNNING
);

    sw_state_t state, state_nxt;
    sw_state_t saved, saved_nxt;
    logic [3:0] blank_nxt;
    logic       sec_inc;
    logic       min_inc;
    logic       sec_carry;
    logic       min_carry;

    // State register, saved-state flag and registered outputs
    always_ff @(posedge CLK_REF or negedge CLK_RES) begin
        if (!CLK_RES) begin
            state   <= PAUSED;
            saved   <= PAUSED;
            BLANK   <= 4'b0000;
            RUNNING <= 1'b0;
        end else begin
            state   <= state_nxt;
            saved   <= saved_nxt;
            BLANK   <= blank_nxt;
            RUNNING <= (state_nxt == RUN);
        end
    end

    always_comb begin
        state_nxt = state;
        saved_nxt = saved;
        blank_nxt = 4'b0000;
        if (ADJ) begin
            state_nxt = ADJUST;
            // Remember where we came from only on the entry cycle
            if (state != ADJUST) begin
                saved_nxt = (state == RUN) ? RUN : PAUSED;
            end
        end else if (state == ADJUST) begin
            state_nxt = saved;
        end else if (PAUSE) begin
            state_nxt = (state == RUN) ? PAUSED : RUN;
        end

        if (state_nxt == ADJUST && BLINK_PH) begin
            if (SEL) begin
                blank_nxt[BLANK_SEC_TENS] = 1'b1;
                blank_nxt[BLANK_SEC_ONES] = 1'b1;
            end else begin
                blank_nxt[BLANK_MIN_TENS] = 1'b1;
                blank_nxt[BLANK_MIN_ONES] = 1'b1;
            end
        end
    end

    // Increments are qualified by the pre-edge state, so a tick arriving with
    // PAUSE in RUN still counts, and one arriving with PAUSE in PAUSED does not.
    // The seconds carry only reaches the minutes while running; adjusting
    // seconds past 59 must leave the minutes alone.
    assign sec_inc = ((state == RUN) && TICK_1HZ) ||
                     ((state == ADJUST) && TICK_2HZ && SEL);
    assign min_inc = ((state == RUN) && sec_carry) ||
                     ((state == ADJUST) && TICK_2HZ && !SEL);

    bcd_mod60 u_sec (
        .clk       (CLK_REF),
        .rst_n     (CLK_RES),
        .inc       (sec_inc),
        .clr       (CLR),
        .tens_max  (4'(SEC_MAX)),
        .tens      (SEC_TENS),
        .ones      (SEC_ONES),
        .carry_out (sec_carry)
    );

    bcd_mod60 u_min (
        .clk       (CLK_REF),
        .rst_n     (CLK_RES),
        .inc       (min_inc),
        .clr       (CLR),
        .tens_max  (4'(MIN_MAX)),
        .tens      (MIN_TENS),
        .ones      (MIN_ONES),
        .carry_out (min_carry)
    );

    // The minutes wrap 59:59 -> 00:00 silently; its carry has no consumer.
    logic unused_min_carry;
    assign unused_min_carry = min_carry;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - directed self-checking bench for stopwatch_core
module tb_stopwatch_core;

    logic       CLK_REF = 1'b0;
    logic       CLK_RES = 1'b1;
    logic       TICK_1HZ = 1'b0;
    logic       TICK_2HZ = 1'b0;
    logic       BLINK_PH = 1'b0;
    logic       PAUSE = 1'b0;
    logic       CLR = 1'b0;
    logic       ADJ = 1'b0;
    logic       SEL = 1'b0;
    logic [3:0] MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES;
    logic [3:0] BLANK;
    logic       RUNNING;

    int errors = 0;
    int checks = 0;

    stopwatch_core #(.MIN_MAX(5), .SEC_MAX(5)) dut (
        .CLK_REF  (CLK_REF),
        .CLK_RES  (CLK_RES),
        .TICK_1HZ (TICK_1HZ),
        .TICK_2HZ (TICK_2HZ),
        .BLINK_PH (BLINK_PH),
        .PAUSE    (PAUSE),
        .CLR      (CLR),
        .ADJ      (ADJ),
        .SEL      (SEL),
        .MIN_TENS (MIN_TENS),
        .MIN_ONES (MIN_ONES),
        .SEC_TENS (SEC_TENS),
        .SEC_ONES (SEC_ONES),
        .BLANK    (BLANK),
        .RUNNING  (RUNNING)
    );

    always #5 CLK_REF = ~CLK_REF;

    function automatic logic [15:0] tm();
        return {MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply the given strobes for exactly one clock, then sample 1 ns after the edge
    task automatic step(input logic t1, input logic t2, input logic p, input logic c);
        TICK_1HZ = t1;
        TICK_2HZ = t2;
        PAUSE    = p;
        CLR      = c;
        @(posedge CLK_REF);
        #1;
        TICK_1HZ = 1'b0;
        TICK_2HZ = 1'b0;
        PAUSE    = 1'b0;
        CLR      = 1'b0;
    endtask

    task automatic ticks1(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic ticks2(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        // Reset
        #2 CLK_RES = 1'b0;
        @(posedge CLK_REF);
        @(posedge CLK_REF);
        #1;
        check("reset_time", tm(), 16'h0000);
        check("reset_blank", {12'd0, BLANK}, 16'h0000);
        check("reset_running", {15'd0, RUNNING}, 16'h0000);
        CLK_RES = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Paused: ticks are ignored
        ticks1(3);
        check("paused_ticks", tm(), 16'h0000);

        // Run and count 61 seconds
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("run_running", {15'd0, RUNNING}, 16'h0001);
        ticks1(61);
        check("count_61", tm(), 16'h0101);

        // CLR in RUN keeps running; CLR beats a simultaneous tick
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_time", tm(), 16'h0000);
        ticks1(9);
        check("count_9", tm(), 16'h0009);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("clr_tick_time", tm(), 16'h0000);
        check("clr_tick_running", {15'd0, RUNNING}, 16'h0001);

        // PAUSE with tick in RUN: tick applied, then paused
        ticks1(5);
        check("count_5", tm(), 16'h0005);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("pause_tick_time", tm(), 16'h0006);
        check("pause_tick_running", {15'd0, RUNNING}, 16'h0000);
        ticks1(1);
        check("paused_hold", tm(), 16'h0006);

        // Adjust from PAUSED: minutes to 59, seconds through the wrap
        ADJ = 1'b1;
        SEL = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("adj_running", {15'd0, RUNNING}, 16'h0000);
        ticks2(59);
        check("adj_min_59", tm(), 16'h5906);
        SEL = 1'b1;
        ticks2(52);
        check("adj_sec_58", tm(), 16'h5958);
        ticks2(1);
        check("adj_sec_59", tm(), 16'h5959);
        ticks2(1);
        check("adj_sec_00", tm(), 16'h5900);
        ticks2(1);
        check("adj_sec_01", tm(), 16'h5901);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("adj_ignores_1hz", tm(), 16'h5901);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        BLINK_PH = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("blank_sec", {12'd0, BLANK}, 16'h0003);
        SEL = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("blank_min", {12'd0, BLANK}, 16'h000c);
        BLINK_PH = 1'b0;
        SEL = 1'b1;
        ticks2(58);
        check("preload_5959", tm(), 16'h5959);
        check("blank_off", {12'd0, BLANK}, 16'h0000);

        // Leave adjust: back to PAUSED (the PAUSE pulse above was ignored)
        ADJ = 1'b0;
        BLINK_PH = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("exit_adj_running", {15'd0, RUNNING}, 16'h0000);
        check("exit_adj_blank", {12'd0, BLANK}, 16'h0000);
        BLINK_PH = 1'b0;

        // Full wrap 59:59 -> 00:00 in RUN
        step(1'b0, 1'b0, 1'b1, 1'b0);
        ticks1(1);
        check("wrap_0000", tm(), 16'h0000);

        // Adjust from RUN to 12:34, return to RUN
        ADJ = 1'b1;
        SEL = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("adj_from_run", {15'd0, RUNNING}, 16'h0000);
        ticks2(12);
        SEL = 1'b1;
        ticks2(34);
        ADJ = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("preload_1234", tm(), 16'h1234);
        check("back_to_run", {15'd0, RUNNING}, 16'h0001);

        // Asynchronous reset between edges
        #3 CLK_RES = 1'b0;
        #1;
        check("async_rst_time", tm(), 16'h0000);
        check("async_rst_running", {15'd0, RUNNING}, 16'h0000);
        check("async_rst_blank", {12'd0, BLANK}, 16'h0000);
        #2 CLK_RES = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        ticks1(2);
        check("post_rst_time", tm(), 16'h0000);
        check("post_rst_running", {15'd0, RUNNING}, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
